// File: rtl/tpu_quant_pkg.sv
// Shared sizes and FSM encoding for the accumulator requantization stage.
package tpu_quant_pkg;
    localparam int LANES     = 16;
    localparam int IN_W      = 20;
    localparam int OUT_W     = 8;
    localparam int SHIFT_W   = 5;
    localparam int CNT_W     = 8;
    localparam int MAX_SHIFT = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/quant_lane.sv
// One lane of requantization: rounding arithmetic shift, optional ReLU, saturation.
module quant_lane #(
    parameter int IN_W    = tpu_quant_pkg::IN_W,
    parameter int OUT_W   = tpu_quant_pkg::OUT_W,
    parameter int SHIFT_W = tpu_quant_pkg::SHIFT_W
) (
    input  logic signed [IN_W-1:0]    x,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu,
    output logic signed [OUT_W-1:0]   y
);
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(1 << (OUT_W-1)));

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    // One guard bit keeps x + 2^(s-1) from overflowing; shift is pre-clamped to 19.
    always_comb begin
        ext  = {x[IN_W-1], x};
        bias = '0;
        if (shift != '0) begin
            bias = (IN_W+1)'(1) << (shift - 1'b1);
        end
        sum     = ext + bias;
        shifted = sum >>> shift;
        if (relu && shifted[IN_W]) begin
            shifted = '0;
        end
        y = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            y = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y = SAT_MIN[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/acc_quantizer.sv
// Systolic-array output stage: per-lane requantization of accumulator vectors into
// a two-stage valid/ready pipeline, with a per-tile row counter tagging the last beat.
module acc_quantizer
    import tpu_quant_pkg::state_e;
#(
    parameter int LANES   = tpu_quant_pkg::LANES,
    parameter int IN_W    = tpu_quant_pkg::IN_W,
    parameter int OUT_W   = tpu_quant_pkg::OUT_W,
    parameter int SHIFT_W = tpu_quant_pkg::SHIFT_W,
    parameter int CNT_W   = tpu_quant_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_relu,
    input  logic [CNT_W-1:0]         cfg_rows,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*IN_W-1:0]    s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [LANES*OUT_W-1:0]   m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done,
    output state_e                   fsm_state
);
    import tpu_quant_pkg::IDLE;
    import tpu_quant_pkg::RUN;
    import tpu_quant_pkg::DRAIN;

    localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(tpu_quant_pkg::MAX_SHIFT);

    state_e                 state;
    state_e                 state_next;
    logic                   done_q;
    logic                   done_next;
    logic [SHIFT_W-1:0]     shift_q;
    logic                   relu_q;
    logic [CNT_W-1:0]       rows_q;
    logic [CNT_W-1:0]       row_cnt;
    logic                   s1_valid;
    logic                   s1_last;
    logic [LANES*OUT_W-1:0] s1_data;
    logic                   s2_valid;
    logic                   s2_last;
    logic [LANES*OUT_W-1:0] s2_data;
    logic [LANES*OUT_W-1:0] quant_data;
    logic                   s2_load;
    logic                   s1_load;
    logic                   in_fire;
    logic                   out_fire;
    logic                   is_last_row;
    logic                   accept_start;

    // Handshake: a beat transfers on a rising edge where valid && ready; valid never
    // waits on ready, and data/last hold steady while valid is high and ready is low.
    assign s2_load      = !s2_valid || m_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign s_ready      = (state == RUN) && s1_load;
    assign in_fire      = s_valid && s_ready;
    assign out_fire     = s2_valid && m_ready;
    assign is_last_row  = (row_cnt == rows_q - 1'b1);
    assign accept_start = (state == IDLE) && start;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        quant_lane #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .SHIFT_W(SHIFT_W)
        ) u_lane (
            .x    (s_data[i*IN_W +: IN_W]),
            .shift(shift_q),
            .relu (relu_q),
            .y    (quant_data[i*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_rows == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (in_fire && is_last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && s2_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            relu_q  <= 1'b0;
            rows_q  <= '0;
            row_cnt <= '0;
        end else if (accept_start) begin
            shift_q <= (cfg_shift > MAX_S) ? MAX_S : cfg_shift;
            relu_q  <= cfg_relu;
            rows_q  <= cfg_rows;
            row_cnt <= '0;
        end else if (in_fire) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_fire;
                s1_last  <= in_fire && is_last_row;
                if (in_fire) begin
                    s1_data <= quant_data;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                s2_last  <= s1_valid && s1_last;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end
    end

    assign m_valid   = s2_valid;
    assign m_data    = s2_data;
    assign m_last    = s2_last;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign fsm_state = state;
endmodule

// File: tb/tb_acc_quantizer.sv
// Directed bench for acc_quantizer: arithmetic vectors, tile sequencing, backpressure, reset.
`timescale 1ns/1ps
module tb_acc_quantizer;
    import tpu_quant_pkg::*;

    localparam int DW = LANES * IN_W;
    localparam int OW = LANES * OUT_W;
    localparam int EW = OW + 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               cfg_relu = 1'b0;
    logic [CNT_W-1:0]   cfg_rows = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [DW-1:0]      s_data = '0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic [OW-1:0]      m_data;
    logic               m_last;
    logic               busy;
    logic               done;
    state_e             fsm_state;

    acc_quantizer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .cfg_shift(cfg_shift),
        .cfg_relu (cfg_relu),
        .cfg_rows (cfg_rows),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [EW-1:0] exp_q[$];
    int            done_cnt = 0;
    int            last_cnt = 0;
    bit            bp_en = 1'b0;
    int            bp_k = 0;
    bit            held_valid = 1'b0;
    logic [EW-1:0] held_beat = '0;

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // m_ready pattern 1,0,0,1 when backpressure is enabled, else held high.
    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? ((bp_k % 4 == 0) || (bp_k % 4 == 3)) : 1'b1;
        bp_k++;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            held_valid = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", EW'(busy), EW'(0));
            end
            if (held_valid) begin
                check("hold_stable", {m_last, m_data}, held_beat);
            end
            if (bp_en && m_valid && !m_ready && dut.s1_valid) begin
                check("s_ready_stall", EW'(s_ready), EW'(0));
            end
            if (m_valid && m_ready) begin
                if (m_last) last_cnt++;
                check("beat_expected", EW'(exp_q.size() != 0), EW'(1));
                if (exp_q.size() != 0) begin
                    check("beat_data", {m_last, m_data}, exp_q.pop_front());
                end
            end
            held_valid = m_valid && !m_ready;
            held_beat  = {m_last, m_data};
        end
    end

    // ---------------- vector helpers ----------------
    function automatic logic [DW-1:0] pack_in(input int a[LANES]);
        logic [DW-1:0] v = '0;
        for (int j = 0; j < LANES; j++) v[(LANES-1-j)*IN_W +: IN_W] = IN_W'(a[j]);
        return v;
    endfunction

    function automatic logic [OW-1:0] pack_out(input int e[LANES]);
        logic [OW-1:0] v = '0;
        for (int j = 0; j < LANES; j++) v[(LANES-1-j)*OUT_W +: OUT_W] = OUT_W'(e[j]);
        return v;
    endfunction

    // In-range values with shift 0 pass through unchanged.
    function automatic logic [DW-1:0] row_in(input int r);
        int a[LANES];
        for (int j = 0; j < LANES; j++) a[j] = ((r * LANES + j) % 200) - 100;
        return pack_in(a);
    endfunction

    function automatic logic [OW-1:0] row_out(input int r);
        int a[LANES];
        for (int j = 0; j < LANES; j++) a[j] = ((r * LANES + j) % 200) - 100;
        return pack_out(a);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_tile(input int shift, input int relu, input int rows);
        @(posedge clk); #1;
        start     = 1'b1;
        cfg_shift = SHIFT_W'(shift);
        cfg_relu  = relu[0];
        cfg_rows  = CNT_W'(rows);
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_shift = 5'd3;
        cfg_relu  = 1'b1;
        cfg_rows  = 8'd99;
    endtask

    task automatic send_vec(input logic [DW-1:0] v);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        s_valid = 1'b0;
        check("send_accepted", EW'(ok), EW'(1));
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, EW'(seen), EW'(1));
    endtask

    task automatic send_rows(input int base, input int first, input int count, input int rows);
        for (int r = first; r < first + count; r++) begin
            exp_q.push_back({r == rows - 1, row_out(base + r)});
            send_vec(row_in(base + r));
        end
    endtask

    task automatic arith(input int shift, input int relu, input int xin[LANES], input int yexp[LANES]);
        start_tile(shift, relu, 1);
        exp_q.push_back({1'b1, pack_out(yexp)});
        send_vec(pack_in(xin));
        wait_done("arith_done");
        repeat (2) @(negedge clk);
        check("arith_drained", EW'(exp_q.size()), EW'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, EW'(s_ready), EW'(0));
        check({tag, "_m_valid"}, EW'(m_valid), EW'(0));
        check({tag, "_m_data"}, EW'(m_data), EW'(0));
        check({tag, "_m_last"}, EW'(m_last), EW'(0));
        check({tag, "_busy"}, EW'(busy), EW'(0));
        check({tag, "_done"}, EW'(done), EW'(0));
        check({tag, "_state"}, EW'(fsm_state), EW'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    int xa[LANES];
    int ya[LANES];
    int d0;
    int l0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // rounding, shift 4
        for (int j = 0; j < LANES; j++) begin xa[j] = 0; ya[j] = 0; end
        xa[0] = 100;     ya[0] = 6;
        xa[1] = -100;    ya[1] = -6;
        xa[2] = 8;       ya[2] = 1;
        xa[3] = 7;       ya[3] = 0;
        xa[4] = -8;      ya[4] = 0;
        xa[5] = -9;      ya[5] = -1;
        xa[6] = 524287;  ya[6] = 127;
        xa[7] = -524288; ya[7] = -128;
        xa[15] = 24;     ya[15] = 2;
        arith(4, 0, xa, ya);

        // shift 0, saturation
        for (int j = 0; j < LANES; j++) begin xa[j] = 0; ya[j] = 0; end
        xa[0] = -3;      ya[0] = -3;
        xa[1] = 524287;  ya[1] = 127;
        xa[2] = -524288; ya[2] = -128;
        xa[3] = 127;     ya[3] = 127;
        xa[4] = 128;     ya[4] = 127;
        xa[5] = -128;    ya[5] = -128;
        xa[6] = -129;    ya[6] = -128;
        xa[7] = 5;       ya[7] = 5;
        arith(0, 0, xa, ya);

        // same inputs with ReLU
        ya[0] = 0; ya[2] = 0; ya[5] = 0; ya[6] = 0;
        arith(0, 1, xa, ya);

        // shift 25 clamps to 19
        for (int j = 0; j < LANES; j++) begin xa[j] = 0; ya[j] = 0; end
        xa[0] = 262144;  ya[0] = 1;
        xa[1] = 262143;  ya[1] = 0;
        xa[2] = -262144; ya[2] = 0;
        xa[3] = -262145; ya[3] = -1;
        xa[4] = 524287;  ya[4] = 1;
        xa[5] = -524288; ya[5] = -1;
        arith(25, 0, xa, ya);

        // shift 1 with ReLU
        for (int j = 0; j < LANES; j++) begin xa[j] = 0; ya[j] = 0; end
        xa[0] = 1;  ya[0] = 1;
        xa[1] = -1; ya[1] = 0;
        xa[2] = 3;  ya[2] = 2;
        xa[3] = -5; ya[3] = 0;
        xa[4] = 300; ya[4] = 127;
        arith(1, 1, xa, ya);

        // 30-row streaming tile with latency check
        d0 = done_cnt;
        l0 = last_cnt;
        start_tile(0, 0, 30);
        check("busy_after_start", EW'(busy), EW'(1));
        fork
            send_rows(0, 0, 30, 30);
            begin
                bit hs = 1'b0;
                bit mv = 1'b0;
                int n = 0;
                for (int t = 0; t < 50 && !hs; t++) begin
                    @(negedge clk);
                    if (s_valid && s_ready) hs = 1'b1;
                end
                check("first_hs_seen", EW'(hs), EW'(1));
                check("m_valid_before_hs", EW'(m_valid), EW'(0));
                for (int t = 0; t < 10 && !mv; t++) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (m_valid) mv = 1'b1;
                end
                check("first_latency", EW'(n), EW'(2));
            end
        join
        check("busy_mid_tile", EW'(busy), EW'(1));
        wait_done("tile30_done");
        repeat (3) @(negedge clk);
        check("tile30_done_count", EW'(done_cnt - d0), EW'(1));
        check("tile30_last_count", EW'(last_cnt - l0), EW'(1));
        check("tile30_drained", EW'(exp_q.size()), EW'(0));
        check("tile30_busy_after", EW'(busy), EW'(0));

        // backpressure over a 16-row tile
        d0 = done_cnt;
        l0 = last_cnt;
        bp_en = 1'b1;
        start_tile(0, 0, 16);
        send_rows(40, 0, 16, 16);
        wait_done("bp_done");
        bp_en = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_done_count", EW'(done_cnt - d0), EW'(1));
        check("bp_last_count", EW'(last_cnt - l0), EW'(1));
        check("bp_drained", EW'(exp_q.size()), EW'(0));

        // zero-row tile
        start_tile(0, 0, 0);
        @(negedge clk);
        check("rows0_done", EW'(done), EW'(1));
        check("rows0_busy", EW'(busy), EW'(0));
        check("rows0_m_valid", EW'(m_valid), EW'(0));
        @(negedge clk);
        check("rows0_done_single", EW'(done), EW'(0));

        // start during RUN is ignored
        d0 = done_cnt;
        start_tile(0, 0, 4);
        send_rows(80, 0, 2, 4);
        start_tile(0, 0, 10);
        check("run_start_state", EW'(fsm_state), EW'(RUN));
        send_rows(80, 2, 2, 4);
        wait_done("run_start_done");
        repeat (3) @(negedge clk);
        check("run_start_done_count", EW'(done_cnt - d0), EW'(1));
        check("run_start_drained", EW'(exp_q.size()), EW'(0));
        check("run_start_idle", EW'(busy), EW'(0));

        // reset mid-tile, then a clean 3-row tile
        start_tile(0, 0, 10);
        send_rows(100, 0, 5, 10);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        reset_n = 1'b1;
        l0 = last_cnt;
        start_tile(0, 0, 3);
        send_rows(120, 0, 3, 3);
        wait_done("post_reset_done");
        repeat (3) @(negedge clk);
        check("post_reset_done_count", EW'(done_cnt - d0), EW'(1));
        check("post_reset_last_count", EW'(last_cnt - l0), EW'(1));
        check("post_reset_drained", EW'(exp_q.size()), EW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/acc_quantizer.md
# acc_quantizer

Output stage of the systolic array. It sits directly downstream of the 16-lane × 20-bit accumulator FIFO and consumes one 16-lane vector of signed 20-bit partial sums per beat. Each lane is requantized to signed 8-bit: rounding arithmetic right shift, optional ReLU, then saturation. The packed 128-bit result goes to the activation buffer over a valid/ready handshake, and a per-tile row counter marks the last beat.

## Interface
Parameters:
- LANES, 16, number of lanes per vector
- IN_W, 20, accumulator width per lane (signed)
- OUT_W, 8, output width per lane (signed)
- SHIFT_W, 5, width of the shift configuration
- CNT_W, 8, width of the row counter

Ports:
- clk  in  1  rising-edge clock; the only clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a tile; ignored unless IDLE
- cfg_shift  in  SHIFT_W  right-shift amount; 0..19 legal, 20..31 treated as 19
- cfg_relu  in  1  when 1, negative results clamp to 0
- cfg_rows  in  CNT_W  number of vectors in the tile
- s_valid  in  1  input vector valid
- s_ready  out  1  block accepts an input vector
- s_data  in  LANES*IN_W  input vector; lane 0 in the MSBs, matching the accumulator FIFO's concatenation order
- m_valid  out  1  output vector valid
- m_ready  in  1  downstream accepts the output vector
- m_data  out  LANES*OUT_W  output vector; lane 0 in the MSBs
- m_last  out  1  high with the beat for row cfg_rows-1
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when the final beat's handshake completes

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - On start, latch cfg_* and clear the row counter.
  - If cfg_rows==0: pulse done on the next cycle and stay in IDLE.
  - Otherwise go to RUN.
- RUN:
  - Each s_valid&&s_ready handshake increments the counter.
  - On the handshake for row cfg_rows-1, tag that beat "last" and go to DRAIN.
- DRAIN:
  - s_ready is 0.
  - When the tagged beat completes m_valid&&m_ready, pulse done and go to IDLE.
- Per-lane arithmetic on x (signed IN_W), with s = min(cfg_shift, 19):
  - s==0: y = x.
  - Otherwise: y = (x + 2^(s-1)) >>> s, computed in IN_W+1 bits. This rounds half toward +inf and cannot overflow.
  - If cfg_relu and y<0: y = 0.
  - Saturate to [-128, 127].
- Config registers change only on an accepted start. The cfg_* inputs are don't-care at all other times.

## Timing
- Pipeline has two register stages:
  - S1: quantize, latching data and the last tag.
  - S2: output register driving m_data, m_valid and m_last.
- Latency is 2 cycles from the input handshake to m_valid, with m_ready held high. Throughput is 1 vector per cycle.
- Ready logic:
  - S2 can load when !v2 || m_ready.
  - S1 can load when !v1 || (S2 can load).
  - s_ready = (state==RUN) && (S1 can load).
- Handshake rules:
  - No beat is lost or duplicated under any m_ready pattern.
  - m_data and m_last stay stable while m_valid && !m_ready.
- Reset:
  - Asynchronous assertion; every output goes to 0, including s_ready, m_valid, m_data, m_last, busy and done.
  - State goes to IDLE; counter and pipeline valids are cleared.
  - Reset mid-tile discards in-flight beats. No done is issued.
- start during RUN or DRAIN is ignored and has no effect on the counter.
- done is asserted the cycle after the final handshake. busy drops in that same cycle.

## Structure
- Package tpu_quant_pkg holds LANES, IN_W, OUT_W, SHIFT_W and the FSM state enum (IDLE/RUN/DRAIN).
- Sub-module quant_lane is combinational: one lane of round, shift, ReLU and saturate. It is instantiated LANES times through generate.
- The top level holds the FSM, the row counter, the S1/S2 registers and the ready chain.

## Test plan
- Rounding: shift=4, relu=0, lanes x=100 and x=-100 → outputs 6 and -6. With shift=0, x=-3 → -3.
- Saturation and ReLU:
  - shift=0, x=524287 → 127; x=-524288 → -128.
  - Same inputs with relu=1 → 127 and 0.
  - shift=25 (clamped to 19), x=262144 → 1.
- Tile of 30 rows with m_ready=1 and continuous s_valid:
  - m_valid first rises 2 cycles after the first handshake.
  - m_last on beat 30 only; done pulses once; busy spans start to done.
- Backpressure: m_ready toggles 1,0,0,1 repeating over a 16-row tile.
  - All 16 vectors arrive in order and unmodified.
  - s_ready is low whenever both stages are full and m_ready=0.
- Edge cases:
  - cfg_rows=0 → done pulse with no beats.
  - start during RUN → ignored, and the tile still ends after cfg_rows beats.
- Reset mid-tile after 5 of 10 rows → all outputs 0 immediately.
  - A following start with rows=3 completes normally, with m_last on beat 3.
